uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, successor to the fixed-rate single-buffer TX. Parallel words enter through a valid-only strobe into an internal FIFO and are serialised LSB-first as start / data / optional parity / 1–2 stop bits, at a bit rate set by a runtime clock divider. It sits between the system-side producer and the serial pin. Overflow is flagged instead of silently dropped.

---
 rtl/uart_tx_fifo.sv | 269 ++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// UART transmitter with an input FIFO. Words written with DATA_VALID are
// queued and serialised LSB first as
//   start(0) / DATA_WIDTH data bits / optional parity / STOP_BITS stop(1)
// Each bit lasts baud_div+1 clock cycles, with baud_div sampled once per frame.
// Writes to a full FIFO are dropped and reported on data_lost.
//
// Ports
//   clk                system clock, rising edge
//   rst                asynchronous active-high reset
//   P_DATA_from_input  word to transmit
//   DATA_VALID         write strobe, one word per high cycle
//   baud_div           bit period minus one, in clk cycles
//   tx_out             serial line, idle high, driven from a flop
//   busy_flag          high whenever a frame is in progress
//   data_lost          one-cycle pulse after a rejected write
//   fifo_full          FIFO holds FIFO_DEPTH words
//   fifo_count         number of words stored
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PAR_EN     = 1,
    parameter int PAR_TYPE   = 1,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       P_DATA_from_input,
    input  logic                        DATA_VALID,
    input  logic [DIV_W-1:0]            baud_div,
    output logic                        tx_out,
    output logic                        busy_flag,
    output logic                        data_lost,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam logic             PAR_ODD  = (PAR_TYPE != 0);
    localparam logic             USE_PAR  = (PAR_EN != 0);
    localparam logic             TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic                  lost_q;

    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic                  full_w;
    logic [DATA_WIDTH-1:0] head;

    // Fullness comes from the registered count, so a write into a full FIFO
    // is rejected even when the transmitter pops in the same cycle.
    assign full_w     = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = DATA_VALID && !full_w;
    assign head       = mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; count and pointers alone decide
    // which entries are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= P_DATA_from_input;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // NOTE: every flop is updated with non-blocking assignments so all
    // registers see the pre-edge values of each other, whatever the order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lost_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lost_q   <= DATA_VALID && full_w;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t                state_q,    state_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_q,      par_d;
    logic [DIV_W-1:0]      div_q,      div_d;
    logic [DIV_W-1:0]      baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q,       tx_d;

    logic                  bit_end;
    logic                  stop_last;
    logic                  load;

    assign bit_end   = (baud_cnt_q == div_q);
    assign stop_last = TWO_STOP ? stop_cnt_q : 1'b1;

    // tx_d carries the line level for the state being entered, so tx_out
    // switches on the same edge as the state and stays a plain flop output.
    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        div_d      = div_q;
        baud_cnt_d = baud_cnt_q + DIV_W'(1);
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        load       = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d    = S_DATA;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        stop_cnt_d = 1'b0;
                        if (USE_PAR) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        // Bit 1 becomes the new LSB, so it is the next level.
                        shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    baud_cnt_d = '0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (!stop_last) begin
                        stop_cnt_d = 1'b1;
                    end else if (!fifo_empty) begin
                        // Back-to-back frame: no idle bit between stop and start.
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            state_d    = S_START;
            shift_d    = head;
            par_d      = (^head) ^ PAR_ODD;
            div_d      = baud_div;
            baud_cnt_d = '0;
            tx_d       = 1'b0;
        end
    end

    assign pop = load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            div_q      <= '0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_out     = tx_q;
    assign busy_flag  = (state_q != S_IDLE);
    assign data_lost  = lost_q;
    assign fifo_full  = full_w;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Two instances: dut_a with the default frame (8 data, odd parity, 1 stop,
// baud_div=3) driven from a table of per-cycle vectors, and dut_b (no parity,
// 2 stop bits) used for the baud_div=0 and mid-frame divisor change cases.
// All inputs change 1 ns after a rising edge and outputs are sampled there.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;

    logic [7:0]  data_a;
    logic        dv_a;
    logic [15:0] baud_a;
    logic        tx_a, busy_a, lost_a, full_a;
    logic [2:0]  cnt_a;

    logic [7:0]  data_b;
    logic        dv_b;
    logic [15:0] baud_b;
    logic        tx_b, busy_b, lost_b, full_b;
    logic [2:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo dut_a (
        .clk               (clk),
        .rst               (rst),
        .P_DATA_from_input (data_a),
        .DATA_VALID        (dv_a),
        .baud_div          (baud_a),
        .tx_out            (tx_a),
        .busy_flag         (busy_a),
        .data_lost         (lost_a),
        .fifo_full         (full_a),
        .fifo_count        (cnt_a)
    );

    uart_tx_fifo #(
        .PAR_EN    (0),
        .STOP_BITS (2)
    ) dut_b (
        .clk               (clk),
        .rst               (rst),
        .P_DATA_from_input (data_b),
        .DATA_VALID        (dv_b),
        .baud_div          (baud_b),
        .tx_out            (tx_b),
        .busy_flag         (busy_b),
        .data_lost         (lost_b),
        .fifo_full         (full_b),
        .fifo_count        (cnt_b)
    );

    // One record per clock edge: inputs applied before the edge, outputs
    // expected just after it.
    typedef struct {
        logic       dv;
        logic [7:0] data;
        logic       exp_tx;
        logic       exp_busy;
        logic       exp_lost;
        logic       exp_full;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    // Line levels in time order, bit 0 first: start, d0..d7, parity, stop.
    logic [10:0] f9_line;
    logic [10:0] l85_line;

    // Default-frame line for any byte: odd parity is the inverse of the XOR.
    function automatic logic [10:0] line_odd(input logic [7:0] d);
        return {1'b1, ~(^d), d, 1'b0};
    endfunction

    task automatic add(input logic dv, input logic [7:0] d, input logic tx,
                       input logic busy, input logic lost, input logic full,
                       input logic [2:0] cnt);
        vec_t v;
        v.dv       = dv;
        v.data     = d;
        v.exp_tx   = tx;
        v.exp_busy = busy;
        v.exp_lost = lost;
        v.exp_full = full;
        v.exp_cnt  = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the write edge: checks each line bit holds for the
    // whole bit period and that busy stays high throughout.
    task automatic expect_line(input string name, input int which, input logic [15:0] seq,
                               input int nbits, input int period);
        logic busy_ok;
        busy_ok = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            logic seen;
            logic cur;
            seen = seq[b];
            for (int c = 0; c < period; c++) begin
                tick();
                cur = (which == 0) ? tx_a : tx_b;
                if (cur !== seq[b]) seen = cur;
                if (((which == 0) ? busy_a : busy_b) !== 1'b1) busy_ok = 1'b0;
            end
            check($sformatf("%s bit%0d", name, b), {31'b0, seen}, {31'b0, seq[b]});
        end
        check($sformatf("%s busy during frame", name), {31'b0, busy_ok}, 32'd1);
    endtask

    initial begin
        logic [7:0]  words [6];
        logic [10:0] lf;
        int          cnt;

        rst    = 1'b1;
        dv_a   = 1'b0;
        data_a = 8'h00;
        baud_a = 16'd3;
        dv_b   = 1'b0;
        data_b = 8'h00;
        baud_b = 16'd0;

        f9_line  = 11'b1_1_11111001_0;
        l85_line = 11'b1_0_10000101_0;
        words[0] = 8'h01;
        words[1] = 8'h3C;
        words[2] = 8'hA5;
        words[3] = 8'hFF;
        words[4] = 8'h80;
        words[5] = 8'h55;

        // ---- vector table -------------------------------------------------
        // Idle after reset.
        for (int i = 0; i < 100; i++) add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // Single 0xF9: 44-cycle frame starting at k+1.
        add(1'b1, 8'hF9, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        for (int i = 0; i < 44; i++) add(1'b0, 8'h00, f9_line[i/4], 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++)  add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // 0xF9 then 0x85 on consecutive edges: 88 busy cycles, no gap.
        add(1'b1, 8'hF9, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        add(1'b1, 8'h85, f9_line[0], 1'b1, 1'b0, 1'b0, 3'd1);
        for (int i = 1; i < 88; i++) begin
            if (i < 44) add(1'b0, 8'h00, f9_line[i/4], 1'b1, 1'b0, 1'b0, 3'd1);
            else        add(1'b0, 8'h00, l85_line[(i-44)/4], 1'b1, 1'b0, 1'b0, 3'd0);
        end
        for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // Six writes on edges k..k+5: the sixth is rejected, five frames follow.
        add(1'b1, words[0], 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        for (int i = 0; i < 220; i++) begin
            lf  = line_odd(words[i/44]);
            cnt = (i < 4) ? i + 1 : 4 - i / 44;
            add((i < 5) ? 1'b1 : 1'b0, (i < 5) ? words[i+1] : 8'h00,
                lf[(i%44)/4], 1'b1, (i == 4) ? 1'b1 : 1'b0,
                (cnt == 4) ? 1'b1 : 1'b0, 3'(cnt));
        end
        for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // ---- reset state --------------------------------------------------
        repeat (3) tick();
        check("reset tx_out", {31'b0, tx_a}, 32'd1);
        check("reset busy", {31'b0, busy_a}, 32'd0);
        check("reset lost/full/count", {27'b0, lost_a, full_a, cnt_a}, 32'd0);
        rst = 1'b0;

        // ---- table run ----------------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            dv_a   = vecs[i].dv;
            data_a = vecs[i].data;
            tick();
            check($sformatf("vec[%0d] {tx,busy,lost,full,cnt}", i),
                  {25'b0, tx_a, busy_a, lost_a, full_a, cnt_a},
                  {25'b0, vecs[i].exp_tx, vecs[i].exp_busy, vecs[i].exp_lost,
                   vecs[i].exp_full, vecs[i].exp_cnt});
        end
        dv_a = 1'b0;

        // ---- dut_b: no parity, 2 stop bits, baud_div=0 ----------------------
        data_b = 8'h00;
        dv_b   = 1'b1;
        tick();
        dv_b = 1'b0;
        check("b write count", {29'b0, cnt_b}, 32'd1);
        expect_line("b 0x00 div0", 1, 16'b00000_11_00000000_0, 11, 1);
        tick();
        check("b idle after frame", {30'b0, busy_b, tx_b}, 32'b01);

        // Divisor changed after the frame has latched it: frame unaffected.
        dv_b = 1'b1;
        tick();
        dv_b = 1'b0;
        tick();
        check("b start bit div0", {30'b0, busy_b, tx_b}, 32'b10);
        baud_b = 16'd5;
        expect_line("b div change mid-frame", 1, 16'b000000_11_00000000, 10, 1);
        tick();
        check("b idle after second frame", {30'b0, busy_b, tx_b}, 32'b01);

        // The next frame picks up the new divisor: 6 cycles per bit.
        data_b = 8'hFF;
        dv_b   = 1'b1;
        tick();
        dv_b = 1'b0;
        expect_line("b 0xFF div5", 1, 16'b00000_11_11111111_0, 11, 6);
        tick();
        check("b idle after div5 frame", {30'b0, busy_b, tx_b}, 32'b01);

        // ---- asynchronous reset mid-frame (dut_a) -------------------------
        data_a = 8'hA5;
        dv_a   = 1'b1;
        tick();
        data_a = 8'h3C;
        tick();
        dv_a = 1'b0;
        check("pre-reset count", {29'b0, cnt_a}, 32'd1);
        repeat (12) tick();
        check("pre-reset busy", {31'b0, busy_a}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset tx/busy", {30'b0, tx_a, busy_a}, 32'b10);
        check("async reset fifo", {27'b0, lost_a, full_a, cnt_a}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("post-reset idle", {27'b0, tx_a, busy_a, cnt_a}, {27'b0, 1'b1, 1'b0, 3'd0});

        data_a = 8'h3C;
        dv_a   = 1'b1;
        tick();
        dv_a = 1'b0;
        expect_line("a 0x3C after reset", 0, {5'b0, line_odd(8'h3C)}, 11, 4);
        tick();
        check("a idle after reset frame", {29'b0, tx_a, busy_a, lost_a}, 32'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
